// File: rtl/mem_access_unit.sv
// Byte-serial load/store unit: splits 8/16-bit core requests into one or two
// accesses to a byte-wide data memory and returns load results with backpressure.
module mem_access_unit #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic             ReqWrite,
    input  logic             ReqWide,
    input  logic [A-1:0]     ReqAddr,
    input  logic [2*W-1:0]   ReqData,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [2*W-1:0]   RspData,
    output logic             MemWriteEn,
    output logic [W-1:0]     MemDataIn,
    output logic [A-1:0]     MemAddress,
    input  logic [W-1:0]     MemDataOut,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_write;
    logic             r_wide;
    logic [A-1:0]     r_addr;
    logic [2*W-1:0]   r_data;
    logic             r_rsp_valid;
    logic [2*W-1:0]   r_rsp_data;
    logic             r_mem_we;
    logic [W-1:0]     r_mem_din;
    logic [A-1:0]     r_mem_addr;
    logic [A-1:0]     w_addr_hi;

    // High byte address wraps naturally at 2^A.
    assign w_addr_hi = r_addr + A'(1);

    assign ReqReady   = (r_state == IDLE);
    assign Busy       = (r_state != IDLE);
    assign RspValid   = r_rsp_valid;
    assign RspData    = r_rsp_data;
    assign MemWriteEn = r_mem_we;
    assign MemDataIn  = r_mem_din;
    assign MemAddress = r_mem_addr;

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the async reset also clears the memory-side outputs at once.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_write     <= 1'b0;
            r_wide      <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_din   <= '0;
            r_mem_addr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ReqValid) begin
                        r_write    <= ReqWrite;
                        r_wide     <= ReqWide;
                        r_addr     <= ReqAddr;
                        r_data     <= ReqData;
                        r_mem_we   <= ReqWrite;
                        r_mem_din  <= ReqData[W-1:0];
                        r_mem_addr <= ReqAddr;
                        r_state    <= LO;
                    end
                end
                LO: begin
                    if (!r_write) begin
                        r_rsp_data[W-1:0] <= MemDataOut;
                    end
                    if (r_wide) begin
                        r_mem_addr <= w_addr_hi;
                        r_mem_din  <= r_data[2*W-1:W];
                        r_state    <= HI;
                    end else begin
                        r_mem_we   <= 1'b0;
                        r_mem_din  <= '0;
                        r_mem_addr <= '0;
                        if (r_write) begin
                            r_state <= IDLE;
                        end else begin
                            r_rsp_data[2*W-1:W] <= '0;
                            r_rsp_valid         <= 1'b1;
                            r_state             <= RESP;
                        end
                    end
                end
                HI: begin
                    r_mem_we   <= 1'b0;
                    r_mem_din  <= '0;
                    r_mem_addr <= '0;
                    if (r_write) begin
                        r_state <= IDLE;
                    end else begin
                        r_rsp_data[2*W-1:W] <= MemDataOut;
                        r_rsp_valid         <= 1'b1;
                        r_state             <= RESP;
                    end
                end
                RESP: begin
                    if (RspReady) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a falling-edge byte memory model.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqValid, ReqWrite, ReqWide, RspReady;
    logic [7:0]  ReqAddr;
    logic [15:0] ReqData;
    logic        ReqReady, RspValid, MemWriteEn, Busy;
    logic [15:0] RspData;
    logic [7:0]  MemDataIn, MemAddress, MemDataOut;

    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;

    logic [7:0]  mem [256];
    logic [7:0]  lat_addr = 8'h00;
    logic [15:0] rsp_q [$];

    always #5 Clk = ~Clk;

    mem_access_unit #(.W(8), .A(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqWide(ReqWide), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData),
        .MemWriteEn(MemWriteEn), .MemDataIn(MemDataIn), .MemAddress(MemAddress),
        .MemDataOut(MemDataOut), .Busy(Busy)
    );

    // Memory latches address and write data on the falling edge, reads asynchronously.
    always @(negedge Clk) begin
        lat_addr <= MemAddress;
        if (MemWriteEn) begin
            mem[MemAddress] <= MemDataIn;
            we_count        <= we_count + 1;
        end
    end
    assign MemDataOut = mem[lat_addr];

    always @(posedge Clk) begin
        if (RspValid && RspReady) rsp_q.push_back(RspData);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic wd, input logic [7:0] addr, input logic [15:0] data);
        int k = 0;
        while (!ReqReady && k < 20) begin
            tick();
            k++;
        end
        check("ready_wait", ReqReady, 1);
        ReqValid = 1'b1; ReqWrite = wr; ReqWide = wd; ReqAddr = addr; ReqData = data;
        tick();
        ReqValid = 1'b0;
    endtask

    task automatic store(input string tag, input logic wd, input logic [7:0] addr, input logic [15:0] data);
        logic [7:0] a1;
        int we0;
        a1 = addr + 8'd1;
        we0 = we_count;
        issue(1'b1, wd, addr, data);
        check({tag, "_lo_we"},   MemWriteEn, 1);
        check({tag, "_lo_addr"}, MemAddress, addr);
        check({tag, "_lo_din"},  MemDataIn, data[7:0]);
        check({tag, "_busy"},    Busy, 1);
        if (wd) begin
            tick();
            check({tag, "_hi_addr"}, MemAddress, a1);
            check({tag, "_hi_din"},  MemDataIn, data[15:8]);
            check({tag, "_hi_ready"}, ReqReady, 0);
        end
        tick();
        check({tag, "_done_we"},    MemWriteEn, 0);
        check({tag, "_done_ready"}, ReqReady, 1);
        check({tag, "_no_rsp"},     RspValid, 0);
        check({tag, "_we_pulses"},  we_count - we0, wd ? 2 : 1);
    endtask

    task automatic load(input string tag, input logic wd, input logic [7:0] addr, input logic [15:0] exp);
        issue(1'b0, wd, addr, 16'h0000);
        check({tag, "_lo_we"}, MemWriteEn, 0);
        check({tag, "_early"}, RspValid, 0);
        if (wd) begin
            tick();
            check({tag, "_early2"}, RspValid, 0);
        end
        tick();
        check({tag, "_valid"}, RspValid, 1);
        check({tag, "_data"},  RspData, exp);
        RspReady = 1'b1;
        tick();
        RspReady = 1'b0;
        check({tag, "_drop"},  RspValid, 0);
        check({tag, "_ready"}, ReqReady, 1);
    endtask

    initial begin
        logic [15:0] held;
        int acc;
        int idx;
        int we0;
        logic [16:0] b2b [4];

        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqWide = 1'b0;
        ReqAddr = 8'h00; ReqData = 16'h0000; RspReady = 1'b0;
        #3;
        check("rst_ready", ReqReady, 1);
        check("rst_busy",  Busy, 0);
        check("rst_rspv",  RspValid, 0);
        check("rst_we",    MemWriteEn, 0);
        #9 Reset = 1'b0;

        // Narrow store then load
        store("n_st", 1'b0, 8'h10, 16'h003C);
        check("n_st_mem", mem[8'h10], 8'h3C);
        load("n_ld", 1'b0, 8'h10, 16'h003C);

        // Wide round trip
        store("w_st", 1'b1, 8'h20, 16'hBEEF);
        check("w_mem20", mem[8'h20], 8'hEF);
        check("w_mem21", mem[8'h21], 8'hBE);
        load("w_ld", 1'b1, 8'h20, 16'hBEEF);

        // Address wrap
        store("wrap_st", 1'b1, 8'hFF, 16'h1234);
        check("wrap_memff", mem[8'hFF], 8'h34);
        check("wrap_mem00", mem[8'h00], 8'h12);
        load("wrap_ld", 1'b1, 8'hFF, 16'h1234);

        // Response backpressure
        issue(1'b0, 1'b0, 8'h20, 16'h0000);
        tick();
        held = RspData;
        check("bp_data0", RspData, 16'h00EF);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", RspValid, 1);
            check("bp_hold",  RspData, held);
            check("bp_ready", ReqReady, 0);
            check("bp_we",    MemWriteEn, 0);
            check("bp_addr",  MemAddress, 0);
            tick();
        end
        RspReady = 1'b1;
        tick();
        RspReady = 1'b0;
        check("bp_idle", ReqReady, 1);
        check("bp_drop", RspValid, 0);

        // Reset in HI of a wide store
        store("pre41", 1'b0, 8'h41, 16'h0000);
        issue(1'b1, 1'b1, 8'h40, 16'hAA55);
        tick();
        check("rh_in_hi", MemAddress, 8'h41);
        Reset = 1'b1;
        #1;
        check("rh_ready", ReqReady, 1);
        check("rh_busy",  Busy, 0);
        check("rh_rspv",  RspValid, 0);
        check("rh_rspd",  RspData, 0);
        check("rh_we",    MemWriteEn, 0);
        check("rh_din",   MemDataIn, 0);
        check("rh_addr",  MemAddress, 0);
        @(negedge Clk);
        #1 Reset = 1'b0;
        check("rh_mem40", mem[8'h40], 8'h55);
        check("rh_mem41", mem[8'h41], 8'h00);

        // First request after reset accepted on the first edge with ReqValid
        ReqValid = 1'b1; ReqWrite = 1'b0; ReqWide = 1'b0; ReqAddr = 8'h40;
        tick();
        ReqValid = 1'b0;
        check("post_rst_accept", Busy, 1);
        tick();
        check("post_rst_data", RspData, 16'h0055);
        RspReady = 1'b1;
        tick();

        // Back-to-back with ReqValid held; {write, wide, addr, data-byte} packed per entry
        b2b[0] = {1'b1, 1'b1, 8'h80, 7'h00};
        b2b[1] = {1'b0, 1'b0, 8'h81, 7'h00};
        b2b[2] = {1'b1, 1'b0, 8'h90, 7'h00};
        b2b[3] = {1'b0, 1'b1, 8'h80, 7'h00};
        rsp_q.delete();
        we0 = we_count;
        idx = 0;
        acc = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            ReqValid = 1'b1;
            ReqWrite = b2b[idx][16];
            ReqWide  = b2b[idx][15];
            ReqAddr  = b2b[idx][14:7];
            ReqData  = (idx == 0) ? 16'h5AA5 : 16'h0077;
            acc = ReqReady ? 1 : 0;
            tick();
            if (acc == 1) idx++;
        end
        ReqValid = 1'b0;
        check("b2b_accepts", idx, 4);
        for (int c = 0; c < 8; c++) tick();
        check("b2b_writes",  we_count - we0, 3);
        check("b2b_rsp_cnt", rsp_q.size(), 2);
        if (rsp_q.size() == 2) begin
            check("b2b_rsp0", rsp_q[0], 16'h005A);
            check("b2b_rsp1", rsp_q[1], 16'h5AA5);
        end
        check("b2b_mem90", mem[8'h90], 8'h77);
        check("b2b_idle",  ReqReady, 1);
        RspReady = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
